serial_add_arbiter: RTL and testbench

Controller that shares one serial adder datapath between two requesters. The datapath is the shift-register operand pair, full adder, carry flip-flop and sum shift-out register. The block arbitrates round-robin, latches the winner's operands, and sequences the datapath through clear, load and WIDTH shifts. It then captures the WIDTH-bit sum and carry-out and returns them to the winner with a one-cycle done pulse. It replaces a single-user controller wherever two producers need additions from the same serial adder.

---
 rtl/serial_add_arbiter.sv | 78 +++++++
 tb/tb_serial_add_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/serial_add_arbiter.sv
// serial_add_arbiter: round-robin controller sharing one serial adder datapath between two requesters
module serial_add_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             busy,
  output logic             dp_clr,
  output logic             dp_load,
  output logic             dp_shr,
  output logic [WIDTH-1:0] dp_a,
  output logic [WIDTH-1:0] dp_b,
  input  logic [WIDTH-1:0] dp_sum,
  input  logic             dp_cout
);
  typedef enum logic [2:0] {IDLE, CLR, LOAD, SHIFT, CAPT} state_t;
  state_t state;
  logic ptr, own, win;
  logic [4:0] cnt;
  // ptr=1 means requester 1 wins a tie
  assign win = req[1] & (~req[0] | ptr);
  assign busy = state != IDLE;
  assign dp_clr = state == CLR;
  assign dp_load = state == LOAD;
  assign dp_shr = state == SHIFT;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      gnt <= '0;
      done <= '0;
      res_sum <= '0;
      res_cout <= 1'b0;
      dp_a <= '0;
      dp_b <= '0;
      ptr <= 1'b0;
      own <= 1'b0;
      cnt <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: if (|req) begin
          own <= win;
          gnt <= win ? 2'b10 : 2'b01;
          dp_a <= win ? a1 : a0;
          dp_b <= win ? b1 : b0;
          state <= CLR;
        end
        CLR: state <= LOAD;
        LOAD: begin
          cnt <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          cnt <= cnt + 5'd1;
          if (cnt == 5'(WIDTH - 1)) state <= CAPT;
        end
        CAPT: begin
          res_sum <= dp_sum;
          res_cout <= dp_cout;
          done <= gnt;
          ptr <= ~own;
          gnt <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_arbiter.sv
// tb_serial_add_arbiter: directed checks of arbitration, sequencing and results against a behavioural serial adder
module tb_serial_add_arbiter;
  localparam int W = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] req = '0, gnt, done;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0, res_sum, dp_a, dp_b, dp_sum;
  logic res_cout, busy, dp_clr, dp_load, dp_shr, dp_cout;
  logic [W-1:0] ra, rb;
  int checks = 0, errors = 0, bad_ctl = 0, gcnt0 = 0, gcnt1 = 0, scnt = 0, dseen = 0;
  logic hold0 = 1'b0;
  logic [1:0] d;
  int lat;

  serial_add_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .req(req), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt(gnt), .done(done), .res_sum(res_sum), .res_cout(res_cout), .busy(busy),
    .dp_clr(dp_clr), .dp_load(dp_load), .dp_shr(dp_shr), .dp_a(dp_a), .dp_b(dp_b),
    .dp_sum(dp_sum), .dp_cout(dp_cout)
  );

  always #5 clk = ~clk;

  // LSB-first serial adder: sum shifts in at the MSB end
  always @(posedge clk) begin
    if (dp_clr) begin
      dp_sum <= '0;
      dp_cout <= 1'b0;
    end else if (dp_load) begin
      ra <= dp_a;
      rb <= dp_b;
    end else if (dp_shr) begin
      dp_sum <= {ra[0] ^ rb[0] ^ dp_cout, dp_sum[W-1:1]};
      dp_cout <= (ra[0] & rb[0]) | (dp_cout & (ra[0] ^ rb[0]));
      ra <= ra >> 1;
      rb <= rb >> 1;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (int'(dp_clr) + int'(dp_load) + int'(dp_shr) > 1) bad_ctl++;
    if (gnt[0]) gcnt0++;
    if (gnt[1]) gcnt1++;
    if (dp_shr) scnt++;
    if (done != 0) dseen++;
    if (gnt[0] && !hold0) req[0] = 1'b0;
    if (gnt[1]) req[1] = 1'b0;
  endtask

  task automatic wait_done(output logic [1:0] dv, output int l);
    gcnt0 = 0; gcnt1 = 0; scnt = 0; dv = '0; l = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (done != 0) begin
        dv = done;
        l = i;
        return;
      end
    end
    chk("timeout", 0, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ctl", {dp_clr, dp_load, dp_shr}, 0);
    chk("rst_sum", res_sum, 0);
    chk("rst_dpa", dp_a, 0);
    // single job from requester 0
    req = 2'b01; a0 = 5; b0 = 6;
    wait_done(d, lat);
    chk("t1_done", d, 1);
    chk("t1_lat", lat, 8);
    chk("t1_gcyc", gcnt0, 7);
    chk("t1_shr", scnt, 4);
    chk("t1_sum", res_sum, 11);
    chk("t1_cout", res_cout, 0);
    step();
    chk("t1_done_pulse", done, 0);
    chk("t1_idle", busy, 0);
    // requester 1 with carry out, then zeros
    req = 2'b10; a1 = 15; b1 = 15;
    wait_done(d, lat);
    chk("t2_done", d, 2);
    chk("t2_sum", res_sum, 14);
    chk("t2_cout", res_cout, 1);
    req = 2'b10; a1 = 0; b1 = 0;
    wait_done(d, lat);
    chk("t2z_sum", res_sum, 0);
    chk("t2z_cout", res_cout, 0);
    // tie after reset goes to 0, then 1, then 0 again
    reset = 1'b1; step(); reset = 1'b0;
    req = 2'b11; a0 = 3; b0 = 4; a1 = 9; b1 = 9;
    wait_done(d, lat);
    chk("t3a_done", d, 1);
    chk("t3a_sum", res_sum, 7);
    chk("t3a_cout", res_cout, 0);
    step();
    chk("t3b_gnt", gnt, 2);
    wait_done(d, lat);
    chk("t3b_done", d, 2);
    chk("t3b_sum", res_sum, 2);
    chk("t3b_cout", res_cout, 1);
    req = 2'b11; a0 = 1; b0 = 1; a1 = 2; b1 = 2;
    step();
    chk("t3c_gnt", gnt, 1);
    wait_done(d, lat);
    chk("t3c_sum", res_sum, 2);
    wait_done(d, lat);
    chk("t3d_done", d, 2);
    chk("t3d_sum", res_sum, 4);
    // operand change after grant is ignored
    req = 2'b01; a0 = 5; b0 = 6;
    step();
    a0 = 1;
    wait_done(d, lat);
    chk("t4_sum", res_sum, 11);
    // reset during the second shift cycle aborts the job
    req = 2'b01; a0 = 2; b0 = 3;
    repeat (4) step();
    chk("t5_in_shift", dp_shr, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_gnt", gnt, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ctl", {dp_clr, dp_load, dp_shr}, 0);
    chk("t5_dpa", dp_a, 0);
    chk("t5_sum", res_sum, 0);
    dseen = 0;
    repeat (12) step();
    chk("t5_nodone", dseen, 0);
    req = 2'b10; a1 = 8; b1 = 7;
    wait_done(d, lat);
    chk("t5b_done", d, 2);
    chk("t5b_sum", res_sum, 15);
    chk("t5b_cout", res_cout, 0);
    // held request starts a second job right after done
    hold0 = 1'b1; req = 2'b01; a0 = 1; b0 = 2;
    wait_done(d, lat);
    chk("t6a_sum", res_sum, 3);
    hold0 = 1'b0;
    step();
    chk("t6_gnt", gnt, 1);
    chk("t6_clr", dp_clr, 1);
    wait_done(d, lat);
    chk("t6b_done", d, 1);
    chk("t6b_lat", lat, 7);
    chk("t6b_sum", res_sum, 3);
    chk("onehot_ctl", bad_ctl, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
